mem_bus_arbiter: RTL and testbench

- Shares the single memory array between the CPU (address register, MI/MO strobes) and a DMA requester.
- The CPU has absolute priority on any cycle where it uses memory. The DMA port receives idle memory cycles.
- If the DMA port is starved too long, the block steals cycles by asserting cpu_hold. cpu_hold is the clock enable that freezes CPU state and T-state advance.
- Sits between the CPU core and the memory module, on the same clock.

---
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 109 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU core, the DMA requester and the memory array.
// The slave view belongs to the arbiter; the master view is the
// surrounding system (CPU, DMA and memory together).
interface mem_bus_arbiter_if;
  // CPU side
  logic [15:0] cpu_addr;
  logic        cpu_mi;
  logic        cpu_mo;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_hold;
  // DMA side
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  // memory side
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  modport slave (
    input  cpu_addr, cpu_mi, cpu_mo, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_hold,
    output dma_ack, dma_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output cpu_addr, cpu_mi, cpu_mo, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_hold,
    input  dma_ack, dma_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: the CPU owns memory whenever it strobes MI/MO, the DMA
// port gets the idle cycles, and a DMA starved for MAX_WAIT cycles steals
// STEAL_LEN cycles by freezing the CPU through cpu_hold.
module mem_bus_arbiter #(
  parameter int MAX_WAIT  = 4,   // 1..255
  parameter int STEAL_LEN = 1    // 1..15
) (
  input  logic               clk,
  input  logic               RST_bar,
  mem_bus_arbiter_if.slave   bus,
  output logic [15:0]        steal_count
);

  typedef enum logic {ARB, STEAL} state_t;

  localparam logic [8:0] WAIT_TRIG  = 9'(MAX_WAIT);
  localparam logic [3:0] STEAL_INIT = 4'(STEAL_LEN - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [3:0]  steal_cnt;
  logic        hold_q;
  logic [15:0] steal_q;

  logic        cpu_use;
  logic        cpu_own;
  logic        dma_own;
  logic [8:0]  wait_inc;
  logic        steal_go;

  // Grant decision. During STEAL the CPU strobes are frozen and ignored;
  // reset suppresses every grant so no access escapes an aborted steal.
  always_comb begin
    cpu_use  = bus.cpu_mi | bus.cpu_mo;
    cpu_own  = RST_bar && (state == ARB) && cpu_use;
    dma_own  = RST_bar && bus.dma_req && ((state == STEAL) || !cpu_use);
    wait_inc = {1'b0, wait_cnt} + 9'd1;
    steal_go = (state == ARB) && bus.dma_req && !dma_own && (wait_inc == WAIT_TRIG);
  end

  // Owner mux onto the memory port; simultaneous MI/MO pass through as-is.
  always_comb begin
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    if (cpu_own) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_we    = bus.cpu_mi;
      bus.mem_re    = bus.cpu_mo;
    end else if (dma_own) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_we    = bus.dma_we;
      bus.mem_re    = !bus.dma_we;
    end
  end

  // Read data is steered only to the current owner.
  always_comb begin
    bus.dma_ack   = dma_own;
    bus.cpu_rdata = cpu_own ? bus.mem_rdata : 16'h0000;
    bus.dma_rdata = dma_own ? bus.mem_rdata : 16'h0000;
    bus.cpu_hold  = hold_q;
    steal_count   = steal_q;
  end

  // Starvation counter and steal FSM; cpu_hold is registered with the state.
  always_ff @(posedge clk) begin
    if (!RST_bar) begin
      state     <= ARB;
      wait_cnt  <= 8'd0;
      steal_cnt <= 4'd0;
      hold_q    <= 1'b0;
      steal_q   <= 16'h0000;
    end else begin
      case (state)
        ARB: begin
          if (steal_go) begin
            state     <= STEAL;
            hold_q    <= 1'b1;
            steal_cnt <= STEAL_INIT;
            wait_cnt  <= 8'd0;
            steal_q   <= steal_q + 16'd1;
          end else if (bus.dma_req && !dma_own) begin
            wait_cnt <= (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
          end else begin
            wait_cnt <= 8'd0;
          end
        end
        STEAL: begin
          // Hold runs its full length even if the DMA drops its request.
          if (steal_cnt == 4'd0) begin
            state  <= ARB;
            hold_q <= 1'b0;
          end else begin
            steal_cnt <= steal_cnt - 4'd1;
          end
        end
        default: begin
          state  <= ARB;
          hold_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two instances (STEAL_LEN 1 and 3),
// each with a small behavioural memory behind the mem_* port.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] steal_a, steal_b;
  logic [15:0] mem_a [0:4095];
  logic [15:0] mem_b [0:4095];
  int          errors = 0;
  int          checks = 0;

  mem_bus_arbiter_if bus_a();
  mem_bus_arbiter_if bus_b();

  mem_bus_arbiter #(.MAX_WAIT(4), .STEAL_LEN(1)) dut_a (
    .clk(clk), .RST_bar(rst_n), .bus(bus_a), .steal_count(steal_a));
  mem_bus_arbiter #(.MAX_WAIT(4), .STEAL_LEN(3)) dut_b (
    .clk(clk), .RST_bar(rst_n), .bus(bus_b), .steal_count(steal_b));

  always #5 clk = ~clk;

  // Memories: combinational read, write on the rising edge; preloaded in reset.
  assign bus_a.mem_rdata = bus_a.mem_re ? mem_a[bus_a.mem_addr[11:0]] : 16'h0000;
  assign bus_b.mem_rdata = bus_b.mem_re ? mem_b[bus_b.mem_addr[11:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) mem_a[i] <= 16'h0000;
      mem_a[12'h200] <= 16'h1234;
      mem_a[12'h000] <= 16'h5A5A;
    end else if (bus_a.mem_we) begin
      mem_a[bus_a.mem_addr[11:0]] <= bus_a.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) mem_b[i] <= 16'h0000;
      mem_b[12'h200] <= 16'h4321;
    end else if (bus_b.mem_we) begin
      mem_b[bus_b.mem_addr[11:0]] <= bus_b.mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_a.cpu_addr = 16'h0; bus_a.cpu_mi = 0; bus_a.cpu_mo = 0; bus_a.cpu_wdata = 16'h0;
    bus_a.dma_req = 0; bus_a.dma_we = 0; bus_a.dma_addr = 16'h0; bus_a.dma_wdata = 16'h0;
    bus_b.cpu_addr = 16'h0; bus_b.cpu_mi = 0; bus_b.cpu_mo = 0; bus_b.cpu_wdata = 16'h0;
    bus_b.dma_req = 0; bus_b.dma_we = 0; bus_b.dma_addr = 16'h0; bus_b.dma_wdata = 16'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    bus_a.cpu_mo = 1; bus_a.dma_req = 1;
    bus_b.cpu_mo = 1; bus_b.dma_req = 1;
    tick(); tick();
    @(negedge clk);
    checks++; if (bus_a.dma_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b want=0", bus_a.dma_ack); end
    checks++; if (bus_a.mem_re !== 1'b0) begin errors++; $display("FAIL rst_re got=%b want=0", bus_a.mem_re); end
    checks++; if (bus_a.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b want=0", bus_a.mem_we); end
    checks++; if (bus_a.cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_hold got=%b want=0", bus_a.cpu_hold); end
    checks++; if (steal_a !== 16'h0) begin errors++; $display("FAIL rst_steal_count got=%h want=0", steal_a); end
    checks++; if (bus_b.cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_hold_b got=%b want=0", bus_b.cpu_hold); end
    tick();
    rst_n = 1;
    clear_inputs();
  endtask

  task automatic test_idle_dma();
    bus_a.dma_req = 1; bus_a.dma_we = 1; bus_a.dma_addr = 16'h0100; bus_a.dma_wdata = 16'hBEEF;
    @(negedge clk);
    checks++; if (bus_a.dma_ack !== 1'b1) begin errors++; $display("FAIL idle_ack got=%b want=1", bus_a.dma_ack); end
    checks++; if (bus_a.mem_we !== 1'b1) begin errors++; $display("FAIL idle_we got=%b want=1", bus_a.mem_we); end
    checks++; if (bus_a.mem_addr !== 16'h0100) begin errors++; $display("FAIL idle_addr got=%h want=0100", bus_a.mem_addr); end
    tick();
    bus_a.dma_req = 0; bus_a.cpu_mo = 1; bus_a.cpu_addr = 16'h0100;
    @(negedge clk);
    checks++; if (bus_a.cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL idle_readback got=%h want=beef", bus_a.cpu_rdata); end
    checks++; if (bus_a.cpu_hold !== 1'b0) begin errors++; $display("FAIL idle_hold got=%b want=0", bus_a.cpu_hold); end
    tick();
    clear_inputs();
  endtask

  task automatic test_starvation();
    bus_a.cpu_mo = 1; bus_a.cpu_addr = 16'h0000;
    bus_a.dma_req = 1; bus_a.dma_we = 0; bus_a.dma_addr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus_a.dma_ack !== 1'b0) begin errors++; $display("FAIL starve_ack[%0d] got=%b want=0", i, bus_a.dma_ack); end
      checks++; if (bus_a.cpu_hold !== 1'b0) begin errors++; $display("FAIL starve_hold[%0d] got=%b want=0", i, bus_a.cpu_hold); end
      checks++; if (bus_a.cpu_rdata !== 16'h5A5A) begin errors++; $display("FAIL starve_cpu_rd[%0d] got=%h want=5a5a", i, bus_a.cpu_rdata); end
      tick();
    end
    @(negedge clk);
    checks++; if (bus_a.cpu_hold !== 1'b1) begin errors++; $display("FAIL steal_hold got=%b want=1", bus_a.cpu_hold); end
    checks++; if (bus_a.dma_ack !== 1'b1) begin errors++; $display("FAIL steal_ack got=%b want=1", bus_a.dma_ack); end
    checks++; if (bus_a.dma_rdata !== 16'h1234) begin errors++; $display("FAIL steal_rdata got=%h want=1234", bus_a.dma_rdata); end
    checks++; if (bus_a.cpu_rdata !== 16'h0000) begin errors++; $display("FAIL steal_cpu_rd got=%h want=0", bus_a.cpu_rdata); end
    checks++; if (steal_a !== 16'd1) begin errors++; $display("FAIL steal_count got=%0d want=1", steal_a); end
    tick();
    bus_a.dma_req = 0;
    @(negedge clk);
    checks++; if (bus_a.cpu_hold !== 1'b0) begin errors++; $display("FAIL steal_end_hold got=%b want=0", bus_a.cpu_hold); end
    checks++; if (bus_a.cpu_rdata !== 16'h5A5A) begin errors++; $display("FAIL steal_end_cpu_rd got=%h want=5a5a", bus_a.cpu_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_steal_len3();
    bus_b.cpu_mo = 1; bus_b.cpu_addr = 16'h0000;
    bus_b.dma_req = 1; bus_b.dma_we = 0; bus_b.dma_addr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus_b.dma_ack !== 1'b0) begin errors++; $display("FAIL len3_deny[%0d] got=%b want=0", i, bus_b.dma_ack); end
      tick();
    end
    @(negedge clk);
    checks++; if (bus_b.cpu_hold !== 1'b1) begin errors++; $display("FAIL len3_hold0 got=%b want=1", bus_b.cpu_hold); end
    checks++; if (bus_b.dma_ack !== 1'b1) begin errors++; $display("FAIL len3_ack0 got=%b want=1", bus_b.dma_ack); end
    checks++; if (bus_b.dma_rdata !== 16'h4321) begin errors++; $display("FAIL len3_rdata got=%h want=4321", bus_b.dma_rdata); end
    tick();
    bus_b.dma_req = 0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus_b.cpu_hold !== 1'b1) begin errors++; $display("FAIL len3_hold[%0d] got=%b want=1", i, bus_b.cpu_hold); end
      checks++; if (bus_b.dma_ack !== 1'b0) begin errors++; $display("FAIL len3_ack[%0d] got=%b want=0", i, bus_b.dma_ack); end
      checks++; if ({bus_b.mem_we, bus_b.mem_re} !== 2'b00) begin errors++; $display("FAIL len3_mem[%0d] got=%b want=00", i, {bus_b.mem_we, bus_b.mem_re}); end
      tick();
    end
    @(negedge clk);
    checks++; if (bus_b.cpu_hold !== 1'b0) begin errors++; $display("FAIL len3_release got=%b want=0", bus_b.cpu_hold); end
    checks++; if (bus_b.mem_re !== 1'b1) begin errors++; $display("FAIL len3_cpu_re got=%b want=1", bus_b.mem_re); end
    checks++; if (steal_b !== 16'd1) begin errors++; $display("FAIL len3_count got=%0d want=1", steal_b); end
    tick();
    clear_inputs();
  endtask

  task automatic test_contention();
    bus_a.cpu_mi = 1; bus_a.cpu_addr = 16'h0010; bus_a.cpu_wdata = 16'h1111;
    bus_a.dma_req = 1; bus_a.dma_we = 1; bus_a.dma_addr = 16'h0010; bus_a.dma_wdata = 16'h2222;
    @(negedge clk);
    checks++; if (bus_a.dma_ack !== 1'b0) begin errors++; $display("FAIL cont_ack got=%b want=0", bus_a.dma_ack); end
    checks++; if (bus_a.mem_wdata !== 16'h1111) begin errors++; $display("FAIL cont_wdata got=%h want=1111", bus_a.mem_wdata); end
    tick();
    checks++; if (mem_a[12'h010] !== 16'h1111) begin errors++; $display("FAIL cont_mem_cpu got=%h want=1111", mem_a[12'h010]); end
    bus_a.cpu_mi = 0;
    @(negedge clk);
    checks++; if (bus_a.dma_ack !== 1'b1) begin errors++; $display("FAIL cont_ack2 got=%b want=1", bus_a.dma_ack); end
    tick();
    checks++; if (mem_a[12'h010] !== 16'h2222) begin errors++; $display("FAIL cont_mem_dma got=%h want=2222", mem_a[12'h010]); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_steal();
    bus_a.cpu_mo = 1; bus_a.dma_req = 1; bus_a.dma_we = 0; bus_a.dma_addr = 16'h0200;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    checks++; if (bus_a.cpu_hold !== 1'b1) begin errors++; $display("FAIL mid_hold got=%b want=1", bus_a.cpu_hold); end
    checks++; if (steal_a !== 16'd2) begin errors++; $display("FAIL mid_count got=%0d want=2", steal_a); end
    rst_n = 0;
    bus_a.cpu_mo = 0; bus_a.cpu_mi = 1; bus_a.cpu_addr = 16'h0300; bus_a.cpu_wdata = 16'hDEAD;
    bus_a.dma_we = 1; bus_a.dma_addr = 16'h0300; bus_a.dma_wdata = 16'hDEAD;
    #1;
    checks++; if (bus_a.mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got=%b want=0", bus_a.mem_we); end
    checks++; if (bus_a.dma_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_ack got=%b want=0", bus_a.dma_ack); end
    checks++; if (bus_a.mem_addr !== 16'h0) begin errors++; $display("FAIL mid_rst_addr got=%h want=0", bus_a.mem_addr); end
    tick();
    rst_n = 1;
    clear_inputs();
    @(negedge clk);
    checks++; if (bus_a.cpu_hold !== 1'b0) begin errors++; $display("FAIL mid_after_hold got=%b want=0", bus_a.cpu_hold); end
    checks++; if (steal_a !== 16'd0) begin errors++; $display("FAIL mid_after_count got=%0d want=0", steal_a); end
    checks++; if (mem_a[12'h300] !== 16'h0000) begin errors++; $display("FAIL mid_no_write got=%h want=0", mem_a[12'h300]); end
    tick();
    // A fresh episode needs four new denials after the aborted steal.
    bus_a.cpu_mo = 1; bus_a.dma_req = 1; bus_a.dma_we = 0; bus_a.dma_addr = 16'h0200;
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    checks++; if (bus_a.cpu_hold !== 1'b0) begin errors++; $display("FAIL mid_rearm_early got=%b want=0", bus_a.cpu_hold); end
    tick();
    @(negedge clk);
    checks++; if (bus_a.cpu_hold !== 1'b1) begin errors++; $display("FAIL mid_rearm_hold got=%b want=1", bus_a.cpu_hold); end
    checks++; if (steal_a !== 16'd1) begin errors++; $display("FAIL mid_rearm_count got=%0d want=1", steal_a); end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_idle_dma();
    test_starvation();
    test_steal_len3();
    test_contention();
    test_reset_mid_steal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
